fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch/sequencing stage directly upstream of the 16-entry program ROM and downstream consumer of its 4-bit opcode output.
- Drives the ROM address from an internal program counter and latches the returned opcode into an instruction register.
- Runs a two-phase FETCH/EXECUTE FSM and presents one opcode per executed instruction to the control/datapath.
- Implements SNZA/SNZS skip-next squashing and end-of-program halt.

Parameters:
- PROG_LEN, 16: number of ROM words executed, 1..16; last executed address is PROG_LEN-1.
- CLR_OPCODE, 4'b0111: NOP/CLR encoding used for reset and squashed slots.
- SNZA_OPCODE, 4'b1000: skip next instruction if A nonzero.
- SNZS_OPCODE, 4'b1001: skip next instruction if S nonzero.

Ports:
- clkIn  input  1  single system clock, rising edge.
- resetIn  input  1  synchronous, active-high reset.
- enableIn  input  1  run enable; low stalls the FSM in place.
- addressOut  output  4  ROM address; equals PC.
- instrIn  input  4  ROM opcode; combinational response to addressOut.
- aNonZeroIn  input  1  datapath flag: register A != 0.
- sNonZeroIn  input  1  datapath flag: register S != 0.
- opcodeOut  output  4  IR contents presented to control.
- execValidOut  output  1  one-cycle strobe: opcodeOut is to be executed this cycle.
- skippedOut  output  1  one-cycle strobe: current EXECUTE slot squashed.
- pcOut  output  4  current PC, for debug/display.
- haltedOut  output  1  program complete; level, held until reset.

Behaviour:
- Reset: on resetIn=1 at a clock edge: PC=0, IR=CLR_OPCODE, state=FETCH, skip flag=0, execValidOut=0, skippedOut=0, haltedOut=0. Reset overrides enableIn and any state, including mid-EXECUTE and HALTED.
- States: FETCH, EXECUTE, HALTED.
- FETCH (enableIn=1): addressOut=PC; at the edge, IR<=instrIn; next state EXECUTE. PC is not changed in FETCH.
- EXECUTE (enableIn=1): opcodeOut=IR.
  - If skip flag=0: execValidOut=1, skippedOut=0.
  - If skip flag=1: execValidOut=0, skippedOut=1, skip flag cleared at the edge.
  - A non-squashed IR==SNZA_OPCODE with aNonZeroIn=1, or IR==SNZS_OPCODE with sNonZeroIn=1, sets the skip flag at the edge. A squashed SNZ never evaluates.
  - Flags are sampled in the EXECUTE cycle only.
  - At the edge: if PC==PROG_LEN-1, next state is HALTED; else PC<=PC+1 and next state is FETCH.
- HALTED: execValidOut=0, skippedOut=0, haltedOut=1, PC holds at PROG_LEN-1. Exit only via reset.
- Stall (enableIn=0): state, PC, IR and skip flag hold; execValidOut=0 and skippedOut=0 regardless of state. No flag sampling while stalled. An instruction stalled in EXECUTE executes exactly once after enableIn returns high.
- Latency/throughput: instruction at address n is presented on addressOut in cycle k and strobed on execValidOut in cycle k+1. Two cycles per instruction.
- Boundaries:
  - A skip flag set by an SNZ at address PROG_LEN-1 is discarded at halt.
  - An SNZ at PROG_LEN-2 squashes the instruction at PROG_LEN-1, then halts.
  - PC is 4-bit; PROG_LEN=16 terminates at address 15 without wrapping.
- opcodeOut is valid in all states; it shows IR, which is CLR_OPCODE after reset.
- execValidOut, skippedOut and haltedOut are registered or decoded from registered state only. No combinational path from instrIn to any output.

Optional Feature:
- Macro: FETCH_LOOP_EN.
- Defined: in EXECUTE with PC==PROG_LEN-1, PC<=0 and next state is FETCH. HALTED is unreachable and haltedOut stays 0. A pending skip flag carries across the wrap and squashes address 0.
- Undefined: halt behaviour exactly as described in Behaviour.

Test Plan:
- Release reset with enableIn=1, ROM = LDA,LDB,ADD,LDO,SUB,LDO,XOR,LDO, then CLR for the rest:
  - execValidOut strobes every 2nd cycle.
  - opcodeOut sequence is 0000,0001,1010,0010,1011,0010,1110,0010, then 0111 ×8.
  - haltedOut=1 after the 16th strobe; pcOut holds 15.
- SNZA at addr 6 with aNonZeroIn=1 during its EXECUTE:
  - addr 7 slot gives execValidOut=0, skippedOut=1.
  - addr 8 executes normally.
- SNZS at addr 6 with sNonZeroIn=0 (aNonZeroIn=1): no skip; addr 7 strobes execValidOut=1.
- enableIn=0 for 3 cycles while in EXECUTE of addr 2 (ADD):
  - no strobes during the stall.
  - after release, ADD strobes exactly once, then addr 3 is fetched.
- resetIn=1 for 1 cycle while pcOut=5 in EXECUTE:
  - next cycle: addressOut=0, opcodeOut=0111, execValidOut=0, haltedOut=0.
  - restart runs from addr 0.
- With FETCH_LOOP_EN defined and SNZA at addr 15 with aNonZeroIn=1:
  - PC wraps to 0.
  - addr 0 slot gives skippedOut=1.
  - addr 1 strobes execValidOut=1.
  - haltedOut remains 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Two-phase FETCH/EXECUTE instruction sequencer with SNZA/SNZS skip-next squashing.
// Optional macro FETCH_LOOP_EN: wrap PC to 0 after the last address instead of halting.

module fetch_sequencer #(
    parameter int         PROG_LEN    = 16,
    parameter logic [3:0] CLR_OPCODE  = 4'b0111,
    parameter logic [3:0] SNZA_OPCODE = 4'b1000,
    parameter logic [3:0] SNZS_OPCODE = 4'b1001
) (
    input  logic       clkIn,
    input  logic       resetIn,
    input  logic       enableIn,
    output logic [3:0] addressOut,
    input  logic [3:0] instrIn,
    input  logic       aNonZeroIn,
    input  logic       sNonZeroIn,
    output logic [3:0] opcodeOut,
    output logic       execValidOut,
    output logic       skippedOut,
    output logic [3:0] pcOut,
    output logic       haltedOut
);

    // state      | meaning
    // ST_FETCH   | ROM addressed by PC, opcode captured into IR at the edge
    // ST_EXECUTE | IR presented to control (or squashed), PC advances
    // ST_HALTED  | program complete, wait for reset
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(PROG_LEN - 1);

    state_t     state, state_nxt;
    logic [3:0] pc, pc_nxt;
    logic [3:0] ir, ir_nxt;
    logic       skip, skip_nxt;
    logic       snz_taken;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state <= ST_FETCH;
            pc    <= 4'd0;
            ir    <= CLR_OPCODE;
            skip  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            skip  <= skip_nxt;
        end
    end

    assign snz_taken = ((ir == SNZA_OPCODE) && aNonZeroIn) ||
                       ((ir == SNZS_OPCODE) && sNonZeroIn);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        skip_nxt  = skip;
        if (enableIn) begin
            case (state)
                ST_FETCH: begin
                    ir_nxt    = instrIn;
                    state_nxt = ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    // a squashed SNZ never evaluates its flag
                    skip_nxt = skip ? 1'b0 : snz_taken;
                    if (pc == LAST_ADDR) begin
`ifdef FETCH_LOOP_EN
                        pc_nxt    = 4'd0;
                        state_nxt = ST_FETCH;
`else
                        skip_nxt  = 1'b0;
                        state_nxt = ST_HALTED;
`endif
                    end else begin
                        pc_nxt    = pc + 4'd1;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        execValidOut = 1'b0;
        skippedOut   = 1'b0;
        haltedOut    = (state == ST_HALTED);
        if (enableIn && (state == ST_EXECUTE)) begin
            execValidOut = !skip;
            skippedOut   = skip;
        end
    end

    assign addressOut = pc;
    assign pcOut      = pc;
    assign opcodeOut  = ir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: program walk, skip-next, stall, reset, and end-of-program.
// Build with FETCH_LOOP_EN defined to exercise the wrap variant instead of halting.

module tb_fetch_sequencer;

    logic       clkIn = 1'b0;
    logic       resetIn = 1'b1;
    logic       enableIn = 1'b1;
    logic [3:0] addressOut;
    logic [3:0] instrIn;
    logic       aNonZeroIn = 1'b0;
    logic       sNonZeroIn = 1'b0;
    logic [3:0] opcodeOut;
    logic       execValidOut;
    logic       skippedOut;
    logic [3:0] pcOut;
    logic       haltedOut;

    logic [3:0] rom [16];
    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer dut (
        .clkIn       (clkIn),
        .resetIn     (resetIn),
        .enableIn    (enableIn),
        .addressOut  (addressOut),
        .instrIn     (instrIn),
        .aNonZeroIn  (aNonZeroIn),
        .sNonZeroIn  (sNonZeroIn),
        .opcodeOut   (opcodeOut),
        .execValidOut(execValidOut),
        .skippedOut  (skippedOut),
        .pcOut       (pcOut),
        .haltedOut   (haltedOut)
    );

    always #5 clkIn = ~clkIn;

    assign instrIn = rom[addressOut];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic load_rom();
        logic [3:0] prog [8];
        prog = '{4'b0000, 4'b0001, 4'b1010, 4'b0010, 4'b1011, 4'b0010, 4'b1110, 4'b0010};
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? prog[i] : 4'b0111;
    endtask

    // reset is sampled at the posedge inside this task; on return the DUT is in FETCH of addr 0
    task automatic do_reset();
        resetIn = 1'b1;
        @(negedge clkIn);
        resetIn = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_op [16];
        exp_op = '{4'b0000, 4'b0001, 4'b1010, 4'b0010, 4'b1011, 4'b0010, 4'b1110, 4'b0010,
                   4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};

        // full program walk
        load_rom();
        do_reset();
        check("rst_addr",   addressOut,   8'h0);
        check("rst_opcode", opcodeOut,    8'h7);
        check("rst_exec",   execValidOut, 8'h0);
        check("rst_skip",   skippedOut,   8'h0);
        check("rst_halt",   haltedOut,    8'h0);
        for (int i = 0; i < 16; i++) begin
            wait_cyc(1);
            check("walk_exec",   execValidOut, 8'h1);
            check("walk_opcode", opcodeOut,    8'(exp_op[i]));
            check("walk_pc",     pcOut,        8'(i));
            if (i < 15) begin
                wait_cyc(1);
                check("walk_fetch_exec", execValidOut, 8'h0);
                check("walk_fetch_addr", addressOut,   8'(i + 1));
            end
        end
        wait_cyc(1);
`ifdef FETCH_LOOP_EN
        check("walk_wrap_pc",   pcOut,     8'h0);
        check("walk_wrap_halt", haltedOut, 8'h0);
`else
        check("walk_halted",    haltedOut,    8'h1);
        check("walk_halt_pc",   pcOut,        8'hf);
        check("walk_halt_exec", execValidOut, 8'h0);
        wait_cyc(3);
        check("walk_halt_hold", haltedOut,    8'h1);
        check("walk_halt_pc2",  pcOut,        8'hf);
`endif

        // SNZA taken at addr 6 squashes addr 7
        load_rom();
        rom[6] = 4'b1000;
        aNonZeroIn = 1'b1;
        do_reset();
        check("snza_rst_halt", haltedOut, 8'h0);
        wait_cyc(13);
        check("snza_exec6",   execValidOut, 8'h1);
        check("snza_op6",     opcodeOut,    8'h8);
        wait_cyc(2);
        check("snza_pc7",     pcOut,        8'h7);
        check("snza_exec7",   execValidOut, 8'h0);
        check("snza_skip7",   skippedOut,   8'h1);
        wait_cyc(2);
        check("snza_exec8",   execValidOut, 8'h1);
        check("snza_skip8",   skippedOut,   8'h0);
        check("snza_pc8",     pcOut,        8'h8);

        // SNZS at addr 6 with S zero does not skip
        load_rom();
        rom[6] = 4'b1001;
        aNonZeroIn = 1'b1;
        sNonZeroIn = 1'b0;
        do_reset();
        wait_cyc(13);
        check("snzs_op6",   opcodeOut,    8'h9);
        wait_cyc(2);
        check("snzs_exec7", execValidOut, 8'h1);
        check("snzs_skip7", skippedOut,   8'h0);
        aNonZeroIn = 1'b0;

        // stall for 3 cycles in EXECUTE of addr 2
        load_rom();
        do_reset();
        wait_cyc(5);
        check("stall_pre_op", opcodeOut, 8'ha);
        enableIn = 1'b0;
        #1;
        check("stall_exec0", execValidOut, 8'h0);
        for (int k = 0; k < 2; k++) begin
            wait_cyc(1);
            check("stall_exec", execValidOut, 8'h0);
            check("stall_skip", skippedOut,   8'h0);
            check("stall_pc",   pcOut,        8'h2);
        end
        wait_cyc(1);
        enableIn = 1'b1;
        #1;
        check("stall_rel_exec", execValidOut, 8'h1);
        check("stall_rel_op",   opcodeOut,    8'ha);
        wait_cyc(1);
        check("stall_post_exec", execValidOut, 8'h0);
        check("stall_post_addr", addressOut,   8'h3);
        wait_cyc(1);
        check("stall_next_exec", execValidOut, 8'h1);
        check("stall_next_op",   opcodeOut,    8'h2);

        // reset mid-EXECUTE at pc 5
        load_rom();
        do_reset();
        wait_cyc(11);
        check("mrst_pre_pc", pcOut, 8'h5);
        do_reset();
        check("mrst_addr",   addressOut,   8'h0);
        check("mrst_opcode", opcodeOut,    8'h7);
        check("mrst_exec",   execValidOut, 8'h0);
        check("mrst_halt",   haltedOut,    8'h0);
        wait_cyc(1);
        check("mrst_restart_exec", execValidOut, 8'h1);
        check("mrst_restart_op",   opcodeOut,    8'h0);

`ifdef FETCH_LOOP_EN
        // SNZA at addr 15: skip carries across wrap and squashes addr 0
        load_rom();
        rom[15] = 4'b1000;
        aNonZeroIn = 1'b1;
        do_reset();
        wait_cyc(31);
        check("wrap_op15",   opcodeOut,    8'h8);
        check("wrap_exec15", execValidOut, 8'h1);
        wait_cyc(1);
        check("wrap_addr0",  addressOut,   8'h0);
        wait_cyc(1);
        check("wrap_skip0",  skippedOut,   8'h1);
        check("wrap_exec0",  execValidOut, 8'h0);
        wait_cyc(2);
        check("wrap_exec1",  execValidOut, 8'h1);
        check("wrap_pc1",    pcOut,        8'h1);
        check("wrap_halt",   haltedOut,    8'h0);
`else
        // SNZA at addr 14 squashes addr 15, then halts with no pending skip
        load_rom();
        rom[14] = 4'b1000;
        aNonZeroIn = 1'b1;
        do_reset();
        wait_cyc(29);
        check("end_op14",   opcodeOut,    8'h8);
        wait_cyc(2);
        check("end_skip15", skippedOut,   8'h1);
        check("end_exec15", execValidOut, 8'h0);
        wait_cyc(1);
        check("end_halt",   haltedOut,    8'h1);
        check("end_hskip",  skippedOut,   8'h0);
        check("end_pc",     pcOut,        8'hf);
`endif
        aNonZeroIn = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
